mem_arbiter: RTL
================

# mem_arbiter

Memory controller between the CPU core and the single byte-wide synchronous RAM port (mem_din/mem_dout/mem_a/mem_wr). It arbitrates between two requesters: instruction fetch (IF, read-only, 4 bytes) and load/store (LS, read or write, 1–4 bytes). It sequences each request into per-byte RAM accesses and assembles or disassembles little-endian 32-bit words. It sits inside cpu, directly on the cpu memory pins.

## Interface
- No parameters.
- clk_in  input  1  system clock, all state on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  gate on starting new transactions
- if_req  input  1  IF read request, held until if_ack
- if_addr  input  32  IF byte address
- if_ack  output  1  one-cycle pulse; if_data valid
- if_data  output  32  fetched word, registered
- ls_req  input  1  LS request, held until ls_ack
- ls_wr  input  1  1 = write, 0 = read
- ls_addr  input  32  LS byte address
- ls_len  input  2  byte count minus one (0..3 → 1..4 bytes)
- ls_wdata  input  32  write data, byte k = bits [8k+7:8k]
- ls_ack  output  1  one-cycle pulse; write done or ls_rdata valid
- ls_rdata  output  32  read data, zero-extended, registered
- mem_din  input  8  RAM read byte, valid the cycle after its address was sampled
- mem_dout  output  8  RAM write byte, registered
- mem_a  output  32  RAM byte address, registered
- mem_wr  output  1  RAM write enable, registered

## Operation
- States: IDLE, READ, WRITE, DONE.
- Reset (async, rst_n_in low): state IDLE; all outputs 0 (if_ack, ls_ack, if_data, ls_rdata, mem_a, mem_dout, mem_wr). The last-owner flag is set to IF. A transaction in flight is abandoned, and no ack is issued.
- IDLE grant condition: rdy_in = 1 and at least one request is pending.
  - If only one request is pending, that requester wins.
  - If both are pending, the requester that was not granted last wins. After reset, LS wins the first tie.
- On grant, the block latches the base address, byte count N (IF: N = 4), the write data, and the owner. Requester fields are not sampled again.
- READ:
  - In cycle k+1 after the grant edge, mem_a = base+k, for k = 0..N-1.
  - The byte at mem_din in cycle k+2 goes to result bits [8k+7:8k]. Result bits above byte N-1 are 0.
- WRITE:
  - In cycle k+1, mem_a = base+k, mem_dout = wdata byte k, mem_wr = 1, for k = 0..N-1.
  - mem_wr returns to 0 on the edge that ends the last byte cycle.
- DONE lasts exactly one cycle:
  - The owner's ack is 1. For reads, the owner's data register was updated at the same edge.
  - No grant happens in DONE. The next state is IDLE.
  - The requester must drop req, or present a new request, at the edge that ends the ack cycle.
- mem_a and mem_dout hold their last values in IDLE and DONE. mem_wr is 0 outside WRITE byte cycles.
- Address arithmetic is modulo 2^32; base+k wraps from 0xFFFFFFFF to 0x00000000.
- rdy_in is sampled only in IDLE. A transaction already started always completes, whatever rdy_in does.
- if_data and ls_rdata hold their values until the next read completes for that port.

## Timing
- Cycle 0 is the cycle whose ending edge performs the grant.
- Read of N bytes: ack is high in cycle N+2 (5 edges after the grant edge for N=4). IDLE resumes in cycle N+3.
- Write of N bytes: ack is high in cycle N+1. IDLE resumes in cycle N+2.
- Back-to-back 4-byte fetches: one per 7 cycles.
- Requests are never preempted. A request that arrives during a transaction waits for IDLE.
- RAM model: address is registered at the edge, and d_out is valid for the following cycle. The controller does not depend on any combinational RAM path.

## Test plan
- IF-only fetch:
  - Stimulus: if_addr = 0x00001000, RAM bytes 13 05 10 00.
  - Required: mem_a steps 0x1000..0x1003 in cycles 1–4; if_ack=1 only in cycle 6 with if_data = 0x00100513; mem_wr stays 0.
- LS write:
  - Stimulus: ls_wr=1, ls_len=1, ls_addr=0x00000200, ls_wdata=0xAABBCCDD.
  - Required: mem_wr=1 with mem_dout DD then CC at 0x200 and 0x201 in cycles 1–2; ls_ack in cycle 3; a following 1-byte read of 0x201 returns ls_rdata = 0x000000CC.
- Simultaneous if_req and ls_req out of reset:
  - Required: LS is granted first, then IF immediately after LS DONE.
  - With both held continuously, grants alternate LS, IF, LS, IF.
- Address wrap:
  - Stimulus: 4-byte LS read at 0xFFFFFFFE.
  - Required: mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- rdy_in behaviour:
  - rdy_in=0 with if_req=1 in IDLE → no grant and mem_a unchanged.
  - rdy_in dropped mid-read → the read still completes, with ack in cycle N+2.
- Reset mid-transaction:
  - Stimulus: rst_n_in low asynchronously during cycle 2 of a write.
  - Required: mem_wr=0 and all acks 0 immediately; after release the block is in IDLE and the first new request is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-wide RAM controller shared by instruction fetch (IF) and
// load/store (LS). Each granted request becomes a run of per-byte RAM accesses.
// Read bytes are assembled into a little-endian word. Write words are split
// into bytes, starting with the lowest byte.
//
// Ports
//   clk_in, rst_n_in     clock (rising edge) and asynchronous active-low reset
//   rdy_in               allows a new grant; only looked at in IDLE
//   if_req/if_addr       IF 4-byte read request
//   if_ack/if_data       IF completion pulse and registered fetched word
//   ls_req/ls_wr/ls_addr/ls_len/ls_wdata
//                        LS request: ls_len is the byte count minus one
//   ls_ack/ls_rdata      LS completion pulse and registered, zero-extended read data
//   mem_din              RAM read byte, valid the cycle after its address was sampled
//   mem_dout/mem_a/mem_wr registered RAM write byte, byte address and write enable
//   fsm_state            current controller state (IDLE=0, READ=1, WRITE=2, DONE=3)
//
// Handshake: a requester raises req with its fields stable and holds them until
// its ack. The ack is a one-cycle pulse in DONE. Fields are sampled only at the
// grant edge. At the edge that ends the ack cycle, the requester either drops
// req or presents its next request. A grant is never preempted.
module mem_arbiter (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_len,
  input  logic [31:0] ls_wdata,
  output logic        ls_ack,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state, state_nxt;

  logic        last_ls;   // 1 when LS received the most recent grant
  logic        owner_ls;  // owner of the transaction in flight
  logic [1:0]  len;       // latched byte count minus one
  logic [2:0]  cyc;       // cycle number after the grant edge (1 = first byte cycle)
  logic [23:0] wbuf;      // write bytes not yet driven on mem_dout
  logic [31:0] result;    // read bytes assembled so far

  logic        grant;
  logic        pick_ls;
  logic        g_wr;
  logic [31:0] g_addr;
  logic [1:0]  g_len;
  logic [2:0]  n_bytes;
  logic [2:0]  byte_idx;
  logic        rd_last;
  logic        wr_last;
  logic [31:0] res_nxt;

  assign fsm_state = state;

  // Grant and arbitration. On a tie, the requester that was not served last
  // wins. After reset last_ls is 0, so LS wins the first tie.
  always_comb begin
    grant   = (state == S_IDLE) && rdy_in && (if_req || ls_req);
    pick_ls = ls_req && (!if_req || !last_ls);
    g_wr    = pick_ls && ls_wr;
    g_addr  = pick_ls ? ls_addr : if_addr;
    g_len   = pick_ls ? ls_len : 2'd3;
  end

  // Read byte k arrives on mem_din in cycle k+2. The last byte is captured at
  // the edge that ends cycle N+1, and DONE follows.
  always_comb begin
    n_bytes  = {1'b0, len} + 3'd1;
    byte_idx = cyc - 3'd2;
    rd_last  = (cyc == n_bytes + 3'd1);
    wr_last  = (cyc == n_bytes);
    res_nxt  = result;
    if (cyc >= 3'd2) begin
      res_nxt[{byte_idx[1:0], 3'b000} +: 8] = mem_din;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant) state_nxt = g_wr ? S_WRITE : S_READ;
      S_READ:  if (rd_last) state_nxt = S_DONE;
      S_WRITE: if (wr_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_ls  <= 1'b0;
      owner_ls <= 1'b0;
      len      <= 2'd0;
      cyc      <= 3'd0;
      wbuf     <= 24'd0;
      result   <= 32'd0;
      if_ack   <= 1'b0;
      if_data  <= 32'd0;
      ls_ack   <= 1'b0;
      ls_rdata <= 32'd0;
      mem_dout <= 8'd0;
      mem_a    <= 32'd0;
      mem_wr   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            last_ls  <= pick_ls;
            owner_ls <= pick_ls;
            len      <= g_len;
            cyc      <= 3'd1;
            result   <= 32'd0;
            mem_a    <= g_addr;
            mem_wr   <= g_wr;
            if (g_wr) begin
              mem_dout <= ls_wdata[7:0];
              wbuf     <= ls_wdata[31:8];
            end
          end
        end
        S_READ: begin
          result <= res_nxt;
          cyc    <= cyc + 3'd1;
          if (cyc < n_bytes) mem_a <= mem_a + 32'd1;
          if (rd_last) begin
            if (owner_ls) begin
              ls_rdata <= res_nxt;
              ls_ack   <= 1'b1;
            end else begin
              if_data <= res_nxt;
              if_ack  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          cyc <= cyc + 3'd1;
          if (wr_last) begin
            mem_wr <= 1'b0;
            if (owner_ls) ls_ack <= 1'b1;
            else          if_ack <= 1'b1;
          end else begin
            mem_a    <= mem_a + 32'd1;
            mem_dout <= wbuf[7:0];
            wbuf     <= {8'd0, wbuf[23:8]};
          end
        end
        S_DONE: begin
          if_ack <= 1'b0;
          ls_ack <= 1'b0;
        end
        default: begin
          if_ack <= 1'b0;
          ls_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule
